mat_inst_fetch: RTL and testbench

MAT_INST_FETCH -- requirements
Module: MatInstFetch

---
 rtl/mat_inst_fetch.sv | 125 ++++++++++++
 tb/tb_mat_inst_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mat_inst_fetch.sv
// Instruction fetch for MatControl: host-loaded program memory streamed out over a valid/ready handshake.
// Optional abort input is enabled with `define MAT_INST_FETCH_ABORT_EN.
module mat_inst_fetch #(
  parameter int         INST_WIDTH  = 32,
  parameter int         DEPTH       = 64,
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  localparam int        ADDR_SIZE   = $clog2(DEPTH),
  localparam int        CNT_SIZE    = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_SIZE-1:0]  load_addr,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic [CNT_SIZE-1:0]   inst_count,
  input  logic                  start,
`ifdef MAT_INST_FETCH_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_data,
  input  logic                  inst_ready,
  output logic [ADDR_SIZE-1:0]  pc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_SIZE-1:0]  DEPTH_CNT = CNT_SIZE'(DEPTH);
  localparam logic [CNT_SIZE-1:0]  ONE_CNT   = CNT_SIZE'(1);
  localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = ADDR_SIZE'(1);

  state_t                state_reg, state_next;
  logic [ADDR_SIZE-1:0]  pc_reg, pc_next, rd_addr;
  logic [CNT_SIZE-1:0]   len_reg, len_next, start_len;
  logic [INST_WIDTH-1:0] data_reg, rd_word;
  logic                  fetch, mem_we, transfer, last, halt;

  logic [INST_WIDTH-1:0] mem [DEPTH];

  assign mem_we    = load_en && (state_reg != RUN);
  assign start_len = (inst_count > DEPTH_CNT) ? DEPTH_CNT : inst_count;
  assign transfer  = (state_reg == RUN) && inst_ready;
  assign last      = (CNT_SIZE'(pc_reg) == (len_reg - ONE_CNT));
  assign halt      = (data_reg[INST_WIDTH-1 -: 4] == HALT_OPCODE);

  // Forward a same-cycle host write so a load coinciding with start is not lost.
  assign rd_word = (mem_we && (load_addr == rd_addr)) ? load_data : mem[rd_addr];

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      len_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      len_reg   <= len_next;
      if (fetch) begin
        data_reg <= rd_word;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    len_next   = len_reg;
    rd_addr    = pc_reg;
    fetch      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next = start_len;
          if (start_len == '0) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            pc_next    = '0;
            rd_addr    = '0;
            fetch      = 1'b1;
          end
        end
      end
      RUN: begin
        if (transfer) begin
          // The final word stays on inst_data and pc never steps past len-1.
          if (last || halt) begin
            state_next = DONE;
          end else begin
            pc_next = pc_reg + ONE_ADDR;
            rd_addr = pc_reg + ONE_ADDR;
            fetch   = 1'b1;
          end
        end
`ifdef MAT_INST_FETCH_ABORT_EN
        if (abort) begin
          state_next = IDLE;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign inst_valid = (state_reg == RUN);
  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign pc         = pc_reg;
  assign inst_data  = data_reg;

endmodule

// File: tb/tb_mat_inst_fetch.sv
// Directed bench for mat_inst_fetch: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mat_inst_fetch;

  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic [CW-1:0] inst_count = '0;
  logic          start = 1'b0;
  logic          inst_valid;
  logic [W-1:0]  inst_data;
  logic          inst_ready = 1'b0;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
`ifdef MAT_INST_FETCH_ABORT_EN
  logic          abort = 1'b0;
`endif

  mat_inst_fetch #(.INST_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .inst_count (inst_count),
    .start      (start),
`ifdef MAT_INST_FETCH_ABORT_EN
    .abort      (abort),
`endif
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_ready (inst_ready),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          go;
    logic [CW-1:0] count;
    logic          ready;
    logic          valid;
    logic [W-1:0]  data;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t        vecs[$];
  logic [W-1:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    model[a]  = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic start_prog(input int count);
    inst_count = CW'(count);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Runs until done, checking each transfer against the memory model; leaves the DUT in IDLE.
  task automatic run_collect(input int max_cycles, output int n, output bit saw_done);
    n = 0;
    saw_done = 1'b0;
    for (int c = 0; c < max_cycles && !saw_done; c++) begin
      if (done) begin
        saw_done = 1'b1;
      end else begin
        if (inst_valid && inst_ready) begin
          check("xfer_pc", 64'(pc), 64'(n));
          check("xfer_data", 64'(inst_data), 64'(model[n]));
          $display("xfer %0d pc=%0d data=%h", n, pc, inst_data);
          n++;
        end
        step();
      end
    end
    check("done_seen", 64'(saw_done), 64'd1);
    step();
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  seen;

    #12;
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_data", 64'(inst_data), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < DEPTH; i++) load(i, W'(32'h10 + i));

    // Full-rate run of 4, then ready toggled 1,0,0, then a zero-length program.
    vecs.push_back('{1'b1, 7'd4, 1'b1, 1'b1, 32'h10, 6'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b1, 1'b1, 32'h11, 6'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b1, 1'b1, 32'h12, 6'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b1, 1'b1, 32'h13, 6'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b0, 32'h13, 6'd3, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b0, 32'h13, 6'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 7'd4, 1'b1, 1'b1, 32'h10, 6'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b1, 32'h11, 6'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b1, 32'h11, 6'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b1, 1'b1, 32'h11, 6'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b1, 32'h12, 6'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b1, 32'h12, 6'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b1, 1'b1, 32'h12, 6'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b1, 32'h13, 6'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b1, 32'h13, 6'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b1, 1'b1, 32'h13, 6'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b0, 32'h13, 6'd3, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b0, 32'h13, 6'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 7'd0, 1'b0, 1'b0, 32'h13, 6'd3, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 7'd0, 1'b0, 1'b0, 32'h13, 6'd3, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].go) start_prog(int'(vecs[i].count));
      check("vec_valid", 64'(inst_valid), 64'(vecs[i].valid));
      check("vec_data", 64'(inst_data), 64'(vecs[i].data));
      check("vec_pc", 64'(pc), 64'(vecs[i].pc));
      check("vec_busy", 64'(busy), 64'(vecs[i].busy));
      check("vec_done", 64'(done), 64'(vecs[i].done));
      $display("vec %0d ready=%0b valid=%0b pc=%0d data=%h done=%0b",
               i, vecs[i].ready, inst_valid, pc, inst_data, done);
      inst_ready = vecs[i].ready;
      step();
    end

    // Oversized count is clamped to DEPTH.
    inst_ready = 1'b1;
    start_prog(DEPTH + 5);
    run_collect(200, n, seen);
    check("clamp_xfers", 64'(n), 64'(DEPTH));

    // Halt opcode at mem[2] stops the program early.
    load(2, 32'hF000_0000);
    inst_ready = 1'b1;
    start_prog(8);
    run_collect(30, n, seen);
    check("halt_xfers", 64'(n), 64'd3);
    load(2, 32'h12);

    // Host write during RUN is ignored; reset mid-run clears outputs immediately.
    inst_ready = 1'b1;
    start_prog(8);
    step();
    load_en   = 1'b1;
    load_addr = AW'(6);
    load_data = 32'hABCD;
    step();
    load_en = 1'b0;
    step();
    check("pre_rst_pc", 64'(pc), 64'd3);
    check("pre_rst_data", 64'(inst_data), 64'h13);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(inst_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_pc", 64'(pc), 64'd0);
    check("mid_rst_data", 64'(inst_data), 64'd0);
    #2;
    reset = 1'b0;
    step();
    start_prog(8);
    run_collect(30, n, seen);
    check("rerun_xfers", 64'(n), 64'd8);

`ifdef MAT_INST_FETCH_ABORT_EN
    inst_ready = 1'b0;
    start_prog(8);
    check("abort_pc0", 64'(pc), 64'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    abort = 1'b1;
    check("abort_pc1", 64'(pc), 64'd1);
    step();
    abort = 1'b0;
    check("abort_valid", 64'(inst_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    step();
    check("abort_done_later", 64'(done), 64'd0);
    inst_ready = 1'b1;
    start_prog(2);
    check("abort_restart_valid", 64'(inst_valid), 64'd1);
    check("abort_restart_pc", 64'(pc), 64'd0);
    run_collect(10, n, seen);
    check("abort_restart_xfers", 64'(n), 64'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
